// File: rtl/spi_cmd_ctrl_if.sv
// Byte-layer link between the SPI slave shifter (master side of this
// interface) and the command controller (slave side).
//
// Handshake: there is no back-pressure. rx_valid is a one-cycle pulse and
// rx_data is meaningful only in that cycle; it is consumed only while
// cs_active is high. tx_load is a one-cycle pulse and tx_data is stable
// while it is high (and holds its value between loads).
interface spi_cmd_ctrl_if;
  logic       cs_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_load;
  logic [7:0] tx_data;

  modport master (
    output cs_active, rx_valid, rx_data,
    input  tx_load, tx_data
  );

  modport slave (
    input  cs_active, rx_valid, rx_data,
    output tx_load, tx_data
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Command controller on top of the SPI byte layer: decodes WRITE (0x02),
// READ (0x03) and READ_STATUS (0x05) frames, owns a small configuration
// register file and feeds read/status bytes back to the MISO shifter.
module spi_cmd_ctrl #(
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  spi_cmd_ctrl_if.slave      bus,
  output logic [8*NREG-1:0]  cfg,
  output logic               wr_strobe,
  output logic [AW-1:0]      wr_addr,
  output logic               led,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    WR_DATA  = 3'd2,
    RD_DATA  = 3'd3,
    DISCARD  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  state_t        state, state_n;
  logic          cmd_rd, cmd_rd_n;
  logic [AW-1:0] ptr, ptr_n, ptr_inc, rx_addr;
  logic [7:0]    regs [NREG];
  logic          wr_sticky, err_sticky;
  logic [7:0]    status;
  logic          do_wr, do_tx, set_err, clr_stat;
  logic [7:0]    tx_n;

  assign ptr_inc   = ptr + AW'(1);
  assign rx_addr   = bus.rx_data[AW-1:0];
  assign status    = {4'h5, 2'b00, wr_sticky, err_sticky};
  assign dbg_state = state;

  // Next-state and per-byte action decode; a dropped chip-select overrides
  // any byte arriving in the same cycle.
  always_comb begin
    state_n  = state;
    cmd_rd_n = cmd_rd;
    ptr_n    = ptr;
    do_wr    = 1'b0;
    do_tx    = 1'b0;
    tx_n     = bus.tx_data;
    set_err  = 1'b0;
    clr_stat = 1'b0;
    if (!bus.cs_active) begin
      state_n  = IDLE;
      cmd_rd_n = 1'b0;
      ptr_n    = '0;
    end else if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          if (bus.rx_data == CMD_WRITE) begin
            state_n  = GET_ADDR;
            cmd_rd_n = 1'b0;
          end else if (bus.rx_data == CMD_READ) begin
            state_n  = GET_ADDR;
            cmd_rd_n = 1'b1;
          end else if (bus.rx_data == CMD_STATUS) begin
            do_tx    = 1'b1;
            tx_n     = status;
            clr_stat = 1'b1;
            state_n  = DISCARD;
          end else begin
            set_err  = 1'b1;
            state_n  = DISCARD;
          end
        end
        GET_ADDR: begin
          ptr_n = rx_addr;
          if (cmd_rd) begin
            state_n = RD_DATA;
            do_tx   = 1'b1;
            tx_n    = regs[rx_addr];
          end else begin
            state_n = WR_DATA;
          end
        end
        WR_DATA: begin
          do_wr = 1'b1;
          ptr_n = ptr_inc;
        end
        RD_DATA: begin
          ptr_n = ptr_inc;
          do_tx = 1'b1;
          tx_n  = regs[ptr_inc];
        end
        default: ;
      endcase
    end
  end

  // FSM, pointer, outputs and sticky status bits; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_rd      <= 1'b0;
      ptr         <= '0;
      bus.tx_load <= 1'b0;
      bus.tx_data <= 8'h00;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_sticky   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_rd      <= cmd_rd_n;
      ptr         <= ptr_n;
      bus.tx_load <= do_tx;
      bus.tx_data <= tx_n;
      wr_strobe   <= do_wr;
      if (do_wr) wr_addr <= ptr;
      wr_sticky   <= do_wr   | (wr_sticky  & ~clr_stat);
      err_sticky  <= set_err | (err_sticky & ~clr_stat);
    end
  end

  // Configuration register file; only a fully received data byte commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (do_wr) begin
      regs[ptr] <= bus.rx_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg
    assign cfg[8*g +: 8] = regs[g];
  end

  assign led = regs[0][0];

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command-level controller that sits on top of the SPI slave byte layer. It consumes received bytes and decodes them into a framed register protocol: WRITE, READ and READ_STATUS. It drives the byte layer's transmit-load path so read data is shifted out on MISO. It also holds a small configuration register file whose outputs drive the rest of the FPGA design, for example the LED.

## Interface
Parameters:
- NREG, 4: number of 8-bit configuration registers; power of two, 2..16.
- AW, $clog2(NREG): register address width. Address bytes use bits [AW-1:0]; upper bits are ignored.

Ports:
- clk  in  1  system (FPGA) clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- cs_active  in  1  synchronized chip-select, high while a frame is in progress.
- rx_valid  in  1  one-cycle pulse: a full byte has been received.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- tx_load  out  1  one-cycle pulse: byte layer loads tx_data into its MISO shift register.
- tx_data  out  8  byte to transmit; stable while tx_load is high.
- cfg  out  8*NREG  register file, flattened; reg i is cfg[8i+7:8i].
- wr_strobe  out  1  one-cycle pulse per committed register write.
- wr_addr  out  AW  address of the write; valid with wr_strobe.
- led  out  1  equals cfg[0].

## Operation
- Frame: interval with cs_active high. The first rx byte of a frame is the command.
- Commands: 0x02 WRITE, 0x03 READ, 0x05 READ_STATUS. Any other value is unknown.
- FSM states: IDLE, GET_ADDR, WR_DATA, RD_DATA, DISCARD.
- IDLE + rx_valid:
  - 0x02 or 0x03 → GET_ADDR, latch the command.
  - 0x05 → pulse tx_load with the status byte, clear the sticky status bits, go to DISCARD.
  - Unknown → set err_sticky, go to DISCARD.
- GET_ADDR + rx_valid: ptr ← rx_data[AW-1:0].
  - WRITE → WR_DATA.
  - READ → RD_DATA, and pulse tx_load with reg[ptr].
- WR_DATA + rx_valid: reg[ptr] ← rx_data; pulse wr_strobe with wr_addr=ptr; ptr ← ptr+1 mod NREG.
- RD_DATA + rx_valid: the byte is a dummy. ptr ← ptr+1 mod NREG; pulse tx_load with reg[ptr+1 mod NREG].
- DISCARD: ignore all rx bytes until the frame ends; no tx_load.
- Status byte: {4'h5, 2'b00, wr_sticky, err_sticky}.
  - wr_sticky is set by any committed write.
  - err_sticky is set by any unknown command.
  - Both are cleared when a status read is issued; an event in the same cycle as the clear wins (bit stays set).
- cs_active low: FSM → IDLE next cycle; ptr and the latched command are discarded. Writes already committed stay. A partial frame never corrupts registers.
- rx_valid while cs_active is low is ignored.

## Timing
- Reset (rst high at a clk edge), all outputs from the following cycle: state IDLE, cfg all 0x00, led 0, tx_load 0, tx_data 0x00, wr_strobe 0, wr_addr 0, ptr 0, both sticky bits 0.
- Reset has priority over everything, including mid-frame; an interrupted frame is lost.
- Latency: tx_load, wr_strobe and the cfg update are all registered, one cycle after the rx_valid that caused them.
- tx_data holds its last loaded value between loads. The byte layer requires tx_load to land before the first SCK falling edge of the next byte, which one cycle satisfies.
- Status and read data are sampled in the rx_valid cycle.
- Write then read of the same address in consecutive frames returns the new value.
- rx_valid in the same cycle as cs_active falling: cs_active wins; the byte is dropped and nothing is written.
- Wrap-around: ptr increments mod NREG, so address NREG-1 is followed by 0.

## Test plan
- Reset then idle: all cfg 0x00, led 0, no tx_load. A 0x05 frame → tx_load with tx_data 0x50.
- Burst write: frame 0x02, 0x02, 0xAA, 0xBB, 0xCC (NREG=4) → reg2=0xAA, reg3=0xBB, reg0=0xCC, led=0. Three wr_strobe pulses, wr_addr 2, 3, 0. A following 0x05 frame returns 0x52; a second 0x05 frame returns 0x50.
- Burst read: preload reg1=0x11, reg2=0x22; frame 0x03, 0x01, dummy, dummy → tx_load with 0x11 after the address byte, then 0x22, then reg3 (0x00).
- Unknown command: frame 0x7E, 0x01, 0xFF → no writes and no tx_load. Next 0x05 frame returns 0x51.
- Aborted write: frame 0x02, 0x01, then cs_active drops in the same cycle as the rx_valid of data 0x99 → reg1 unchanged, no wr_strobe. The next frame's first byte is decoded as a command.
- Reset mid-read: assert rst during RD_DATA → state IDLE, cfg 0x00, tx_data 0x00. A subsequent 0x05 frame returns 0x50.
